// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte requesters.
// Each grant is a one-cycle TX_Start followed by a wait for TX_BUSY to rise and fall.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int BUSY_TIMEOUT = 16,
    parameter int CW           = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   ack,
    output logic                 TX_Start,
    output logic [7:0]           TX_DATA,
    input  logic                 TX_BUSY,
    output logic [2:0]           owner,
    output logic                 active,
    output logic                 timeout_err
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

    state_t                   state, state_n;
    logic [IW-1:0]            last_grant, last_n;
    logic [IW-1:0]            win;
    logic                     found;
    logic [CW-1:0]            cnt, cnt_n;
    logic [NUM_REQ-1:0]       ack_n;
    logic                     start_n;
    logic [7:0]               data_n;
    logic [2:0]               owner_n;
    logic                     terr_n;
    logic [NUM_REQ-1:0][7:0]  req_bytes;

    assign req_bytes = req_data;

    // Two passes: first requesters above last_grant, then wrap to the bottom.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i] && (i > int'(last_grant))) begin
                found = 1'b1;
                win   = IW'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i]) begin
                found = 1'b1;
                win   = IW'(i);
            end
        end
    end

    always_comb begin
        state_n = state;
        last_n  = last_grant;
        owner_n = owner;
        ack_n   = '0;
        start_n = 1'b0;
        data_n  = TX_DATA;
        cnt_n   = cnt;
        terr_n  = timeout_err;
        unique case (state)
            IDLE: begin
                if (!TX_BUSY && found) begin
                    ack_n[win] = 1'b1;
                    start_n    = 1'b1;
                    data_n     = req_bytes[win];
                    owner_n    = 3'(win);
                    last_n     = win;
                    state_n    = ISSUE;
                end
            end
            ISSUE: begin
                cnt_n   = '0;
                state_n = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (TX_BUSY) begin
                    state_n = WAIT_DONE;
                end else if (cnt == CW'(BUSY_TIMEOUT - 1)) begin
                    // Transmitter never picked the byte up; drop it, no retry.
                    terr_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!TX_BUSY) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            last_grant  <= IW'(NUM_REQ - 1);
            owner       <= '0;
            ack         <= '0;
            TX_Start    <= 1'b0;
            TX_DATA     <= '0;
            cnt         <= '0;
            timeout_err <= 1'b0;
            active      <= 1'b0;
        end else begin
            state       <= state_n;
            last_grant  <= last_n;
            owner       <= owner_n;
            ack         <= ack_n;
            TX_Start    <= start_n;
            TX_DATA     <= data_n;
            cnt         <= cnt_n;
            timeout_err <= terr_n;
            active      <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: expected grants are queued at stimulus time
// and a forked monitor pops and compares them on every TX_Start/ack.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [15:0] req_data;
    logic [1:0]  ack;
    logic        TX_Start;
    logic [7:0]  TX_DATA;
    logic        TX_BUSY;
    logic [2:0]  owner;
    logic        active;
    logic        timeout_err;

    logic        force_busy;
    logic        busy_en;
    int          frame_len;
    logic        model_busy;
    int          dly;
    int          blen;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [2:0] idx;
        logic [7:0] data;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    assign TX_BUSY = force_busy | model_busy;

    uart_tx_arbiter #(.NUM_REQ(2), .BUSY_TIMEOUT(16), .CW(5)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data),
        .ack(ack), .TX_Start(TX_Start), .TX_DATA(TX_DATA), .TX_BUSY(TX_BUSY),
        .owner(owner), .active(active), .timeout_err(timeout_err)
    );

    // Transmitter model: busy rises a couple of cycles after TX_Start, lasts frame_len cycles.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            model_busy <= 1'b0;
            dly        <= 0;
            blen       <= 0;
        end else if (TX_Start && busy_en) begin
            dly <= 2;
        end else if (dly != 0) begin
            dly <= dly - 1;
            if (dly == 1) begin
                model_busy <= 1'b1;
                blen       <= frame_len;
            end
        end else if (model_busy) begin
            if (blen <= 1) model_busy <= 1'b0;
            else           blen <= blen - 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic expire(input string nm);
        checks++;
        failures++;
        $display("FAIL %s actual=no_event expected=event_within_bound", nm);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && (TX_Start || ack != 2'b00)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_grant actual_ack=%b expected=none", ack);
                end else begin
                    e = exp_q.pop_front();
                    chk("grant_start", 32'(TX_Start), 1);
                    chk("grant_ack",   32'(ack),      32'(1) << e.idx);
                    chk("grant_data",  32'(TX_DATA),  32'(e.data));
                    chk("grant_owner", 32'(owner),    32'(e.idx));
                end
            end
        end
    endtask

    task automatic push(input int idx, input logic [7:0] d);
        exp_t e;
        e.idx  = 3'(idx);
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_start(input string nm);
        bit seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (TX_Start) seen = 1'b1;
        end
        if (!seen) expire(nm);
    endtask

    task automatic wait_idle(input string nm);
        bit done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            if (!active && !TX_BUSY) done = 1'b1;
        end
        if (!done) expire(nm);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int n;
        bit ok;
        reset      = 1'b0;
        req        = 2'b00;
        req_data   = 16'h0000;
        force_busy = 1'b0;
        busy_en    = 1'b1;
        frame_len  = 1000;
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack",   32'(ack),         0);
        chk("rst_start", 32'(TX_Start),    0);
        chk("rst_data",  32'(TX_DATA),     0);
        chk("rst_owner", 32'(owner),       0);
        chk("rst_active",32'(active),      0);
        chk("rst_terr",  32'(timeout_err), 0);
        @(negedge clk);
        reset = 1'b1;

        // Single request, one-cycle latency, long frame
        @(posedge clk); #1;
        push(0, 8'h41);
        req_data = 16'h0041;
        req      = 2'b01;
        @(negedge clk);
        chk("t1_lat_before", 32'(TX_Start), 0);
        @(negedge clk);
        chk("t1_start", 32'(TX_Start), 1);
        req = 2'b00;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (TX_BUSY) ok = 1'b1;
        end
        if (!ok) expire("t1_busy_rise");
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (!TX_BUSY) ok = 1'b1;
        end
        if (!ok) expire("t1_busy_fall");
        chk("t1_active_at_fall", 32'(active), 1);
        @(negedge clk);
        chk("t1_active_after", 32'(active), 0);
        chk("t1_terr", 32'(timeout_err), 0);

        // Contention from fresh reset: 0,1,0,1
        pulse_reset();
        frame_len = 8;
        push(0, 8'hAA); push(1, 8'h55); push(0, 8'hAA); push(1, 8'h55);
        @(posedge clk); #1;
        req_data = 16'h55AA;
        req      = 2'b11;
        for (int g = 0; g < 4; g++) wait_start("t2_grant");
        req = 2'b00;
        wait_idle("t2_idle");
        chk("t2_terr", 32'(timeout_err), 0);

        // Fairness: lone req[1] after grant to 1, then both -> 0
        push(1, 8'h33);
        @(posedge clk); #1;
        req_data = 16'h33AA;
        req      = 2'b10;
        wait_start("t3_grant1");
        req = 2'b00;
        wait_idle("t3_idle1");
        push(0, 8'hAA);
        @(posedge clk); #1;
        req = 2'b11;
        wait_start("t3_grant0");
        req = 2'b00;
        wait_idle("t3_idle2");

        // Timeout: transmitter never goes busy
        busy_en = 1'b0;
        push(1, 8'h7E);
        @(posedge clk); #1;
        req_data = 16'h7E00;
        req      = 2'b10;
        wait_start("t4_grant");
        req = 2'b00;
        repeat (16) @(negedge clk);
        chk("t4_active_last_wait", 32'(active), 1);
        chk("t4_terr_before", 32'(timeout_err), 0);
        @(negedge clk);
        chk("t4_active_after", 32'(active), 0);
        chk("t4_terr_set", 32'(timeout_err), 1);
        busy_en = 1'b1;
        push(0, 8'h5A);
        @(posedge clk); #1;
        req_data = 16'h005A;
        req      = 2'b01;
        wait_start("t4_next_grant");
        req = 2'b00;
        wait_idle("t4_idle");
        chk("t4_terr_sticky", 32'(timeout_err), 1);

        // Busy gate at reset release
        @(negedge clk);
        reset      = 1'b0;
        force_busy = 1'b1;
        req_data   = 16'h0011;
        req        = 2'b01;
        push(0, 8'h11);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (TX_Start) n++;
        end
        chk("t5_no_grant", 32'(n), 0);
        chk("t5_idle", 32'(active), 0);
        @(posedge clk); #1;
        force_busy = 1'b0;
        @(negedge clk);
        chk("t5_lat_before", 32'(ack), 0);
        @(negedge clk);
        chk("t5_ack", 32'(ack), 1);
        req = 2'b00;
        wait_idle("t5_idle");

        // Async reset in WAIT_DONE
        frame_len = 30;
        push(1, 8'h22);
        @(posedge clk); #1;
        req_data = 16'h2200;
        req      = 2'b10;
        wait_start("t6_grant");
        req = 2'b00;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (TX_BUSY) ok = 1'b1;
        end
        if (!ok) expire("t6_busy_rise");
        repeat (3) @(negedge clk);
        chk("t6_active_mid", 32'(active), 1);
        chk("t6_owner_mid",  32'(owner),  1);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_ack",    32'(ack),         0);
        chk("t6_start",  32'(TX_Start),    0);
        chk("t6_data",   32'(TX_DATA),     0);
        chk("t6_owner",  32'(owner),       0);
        chk("t6_active", 32'(active),      0);
        chk("t6_terr",   32'(timeout_err), 0);
        req_data = 16'h55AA;
        req      = 2'b11;
        push(0, 8'hAA);
        @(negedge clk);
        reset = 1'b1;
        wait_start("t6_first_grant");
        req = 2'b00;
        wait_idle("t6_idle");

        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
